// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz round controller.
// The answer key lives here as a packed constant. The only module that indexes it is
// quiz_answer_key.
package quiz_pkg;

  localparam int ROUND_W    = 2;
  localparam int ANS_W      = 2;
  localparam int SCORE_W    = 3;
  localparam int PAT_W      = 2;
  localparam int NUM_ROUNDS = 4;
  localparam int NUM_PATS   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW,
    ST_WAIT_ANS,
    ST_JUDGE,
    ST_RESULT,
    ST_DONE
  } state_t;

  // KEY[pattern][round]. The ranges ascend, so the first entry of the concatenation is
  // pattern 0, question 0.
  localparam logic [0:NUM_PATS-1][0:NUM_ROUNDS-1][ANS_W-1:0] KEY = {
    2'd1, 2'd0, 2'd3, 2'd2,   // pattern 0
    2'd2, 2'd3, 2'd0, 2'd1,   // pattern 1
    2'd3, 2'd2, 2'd1, 2'd0,   // pattern 2
    2'd0, 2'd2, 2'd1, 2'd3    // pattern 3
  };

endpackage

// File: rtl/quiz_answer_key.sv
// Combinational answer judge: (pattern, round, ans) -> match.
// Each of the four questions of the pattern is compared against the answer in parallel.
// The current round then picks one of those results.
module quiz_answer_key
  import quiz_pkg::*;
(
  input  logic [PAT_W-1:0]   pattern,
  input  logic [ROUND_W-1:0] round,
  input  logic [ANS_W-1:0]   ans,
  output logic               match
);

  logic [NUM_ROUNDS-1:0] hit;

  for (genvar gi = 0; gi < NUM_ROUNDS; gi++) begin : g_q
    assign hit[gi] = (KEY[pattern][gi] == ans);
  end

  assign match = hit[round];

endmodule

// File: rtl/quiz_round_ctrl.sv
// Four-question quiz game sequencer.
// It latches the game pattern and shows each question for SHOW_CYCLES cycles. It then waits
// for one answer, judges it, holds the verdict for RESULT_CYCLES cycles, and advances.
// Optional feature: define QUIZ_TIMEOUT_EN to close the answer window after TIMEOUT_CYCLES
// cycles. A timed-out question counts as wrong and does not change the score.
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int SHOW_CYCLES    = 8,
  parameter int RESULT_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PAT_W-1:0]   pattern_sel,
  input  logic               ans_valid,
  input  logic [ANS_W-1:0]   ans,
  output logic [ROUND_W-1:0] round,
  output logic [PAT_W-1:0]   pattern,
  output logic               show_q,
  output logic               wait_ans,
  output logic               correct,
  output logic               wrong,
  output logic [SCORE_W-1:0] score,
  output logic               done
);

  // One counter serves SHOW, RESULT and the optional answer window. It must hold the
  // longest phase length minus one.
  localparam int MAX_SR  = (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
  localparam int MAX_CYC = (MAX_SR > TIMEOUT_CYCLES) ? MAX_SR : TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]   SHOW_LAST   = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RESULT_LAST = CNT_W'(RESULT_CYCLES - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND  = ROUND_W'(NUM_ROUNDS - 1);
`ifdef QUIZ_TIMEOUT_EN
  localparam logic [CNT_W-1:0]   WINDOW_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t state_reg, state_next;

  logic [CNT_W-1:0]   phase_cnt_reg;
  logic [ROUND_W-1:0] round_reg;
  logic [PAT_W-1:0]   pattern_reg;
  logic [SCORE_W-1:0] score_reg;
  logic               done_reg;
  logic [ANS_W-1:0]   ans_reg;
  logic               verdict_reg;   // 1 = last judged answer was right

  // Control strobes decoded from the state machine.
  logic game_start, cnt_clr, cnt_run, ans_load, judge, timeout_hit, round_adv, game_end;
  logic match;

  quiz_answer_key u_key (
    .pattern (pattern_reg),
    .round   (round_reg),
    .ans     (ans_reg),
    .match   (match)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and decoding of the datapath control strobes.
  always_comb begin
    state_next  = state_reg;
    game_start  = 1'b0;
    cnt_clr     = 1'b0;
    cnt_run     = 1'b0;
    ans_load    = 1'b0;
    judge       = 1'b0;
    timeout_hit = 1'b0;
    round_adv   = 1'b0;
    game_end    = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_SHOW;
          game_start = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      ST_SHOW: begin
        cnt_run = 1'b1;
        if (phase_cnt_reg == SHOW_LAST) begin
          state_next = ST_WAIT_ANS;
          cnt_clr    = 1'b1;
        end
      end
      ST_WAIT_ANS: begin
`ifdef QUIZ_TIMEOUT_EN
        cnt_run = 1'b1;
`endif
        // An answer in the last window cycle still wins over the timeout.
        if (ans_valid) begin
          state_next = ST_JUDGE;
          ans_load   = 1'b1;
        end
`ifdef QUIZ_TIMEOUT_EN
        else if (phase_cnt_reg == WINDOW_LAST) begin
          state_next  = ST_RESULT;
          timeout_hit = 1'b1;
          cnt_clr     = 1'b1;
        end
`endif
      end
      ST_JUDGE: begin
        state_next = ST_RESULT;
        judge      = 1'b1;
        cnt_clr    = 1'b1;
      end
      ST_RESULT: begin
        cnt_run = 1'b1;
        if (phase_cnt_reg == RESULT_LAST) begin
          cnt_clr = 1'b1;
          if (round_reg == LAST_ROUND) begin
            state_next = ST_DONE;
            game_end   = 1'b1;
          end else begin
            state_next = ST_SHOW;
            round_adv  = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Shared phase counter. It is cleared on every phase entry and counts only in timed phases.
  always_ff @(posedge clk) begin
    if (reset)        phase_cnt_reg <= '0;
    else if (cnt_clr) phase_cnt_reg <= '0;
    else if (cnt_run) phase_cnt_reg <= phase_cnt_reg + CNT_W'(1);
  end

  // Game datapath: pattern, round, score, captured answer, verdict and done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_reg <= '0;
      round_reg   <= '0;
      score_reg   <= '0;
      done_reg    <= 1'b0;
      ans_reg     <= '0;
      verdict_reg <= 1'b0;
    end else begin
      if (game_start) begin
        pattern_reg <= pattern_sel;
        round_reg   <= '0;
        score_reg   <= '0;
        done_reg    <= 1'b0;
      end
      if (ans_load) ans_reg <= ans;
      if (judge) begin
        verdict_reg <= match;
        if (match) score_reg <= score_reg + SCORE_W'(1);
      end
      if (timeout_hit) verdict_reg <= 1'b0;
      if (round_adv)   round_reg   <= round_reg + ROUND_W'(1);
      if (game_end)    done_reg    <= 1'b1;
    end
  end

  assign round    = round_reg;
  assign pattern  = pattern_reg;
  assign score    = score_reg;
  assign done     = done_reg;
  assign show_q   = (state_reg == ST_SHOW);
  assign wait_ans = (state_reg == ST_WAIT_ANS);
  assign correct  = (state_reg == ST_RESULT) &&  verdict_reg;
  assign wrong    = (state_reg == ST_RESULT) && !verdict_reg;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Scoreboard bench for quiz_round_ctrl.
// The driver plays games and pushes the expected verdict, score, round and arrival cycle
// for each answer. A monitor pops one entry per result pulse and also checks the show and
// result phase lengths. The reference model uses the answer key table and a plain count of
// correct answers. Define QUIZ_TIMEOUT_EN to also exercise the answer-window timeout.
module tb_quiz_round_ctrl;

  localparam int SHOW_C    = 8;
  localparam int RESULT_C  = 4;
  localparam int TIMEOUT_C = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] pattern_sel;
  logic       ans_valid;
  logic [1:0] ans;
  logic [1:0] round;
  logic [1:0] pattern;
  logic       show_q, wait_ans, correct, wrong, done;
  logic [2:0] score;

  quiz_round_ctrl #(
    .SHOW_CYCLES    (SHOW_C),
    .RESULT_CYCLES  (RESULT_C),
    .TIMEOUT_CYCLES (TIMEOUT_C)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pattern_sel (pattern_sel),
    .ans_valid   (ans_valid),
    .ans         (ans),
    .round       (round),
    .pattern     (pattern),
    .show_q      (show_q),
    .wait_ans    (wait_ans),
    .correct     (correct),
    .wrong       (wrong),
    .score       (score),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ok;
    int score;
    int rnd;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   key[4][4];
  int   tests = 0;
  int   fails = 0;
  int   m_pat = 0;
  int   m_score = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Monitor: one scoreboard pop per result pulse, plus phase-length checks.
  int show_run = 0, res_run = 0;
  bit prev_res = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    bit cur;
    if (reset) begin
      show_run = 0;
      res_run  = 0;
      prev_res = 1'b0;
    end else begin
      cur = correct | wrong;
      if (cur && !prev_res) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: correct=%0d wrong=%0d with empty scoreboard (cycle %0d)",
                   correct, wrong, cyc);
        end else begin
          e = sb.pop_front();
          check("correct", int'(correct), e.ok);
          check("wrong", int'(wrong), 1 - e.ok);
          check("score", int'(score), e.score);
          check("result_round", int'(round), e.rnd);
          check("result_cycle", cyc, e.cyc);
          $display("[TB] round %0d: correct=%0d wrong=%0d score=%0d at cycle %0d",
                   round, correct, wrong, score, cyc);
        end
      end
      if (show_q) show_run++;
      else if (show_run != 0) begin
        check("show_len", show_run, SHOW_C);
        show_run = 0;
      end
      if (cur) res_run++;
      else if (res_run != 0) begin
        check("result_len", res_run, RESULT_C);
        res_run = 0;
      end
      prev_res = cur;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_round"}, int'(round), 0);
    check({tag, "_pattern"}, int'(pattern), 0);
    check({tag, "_show_q"}, int'(show_q), 0);
    check({tag, "_wait_ans"}, int'(wait_ans), 0);
    check({tag, "_correct"}, int'(correct), 0);
    check({tag, "_wrong"}, int'(wrong), 0);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // Issue a start pulse from IDLE or DONE and check the freshly initialised game.
  task automatic start_game(input int p);
    logic [1:0] ps;
    ps = 2'(p);
    @(negedge clk);
    start = 1'b1;
    pattern_sel = ps;
    @(negedge clk);
    start = 1'b0;
    pattern_sel = 2'($urandom);
    m_pat = p;
    m_score = 0;
    check("start_pattern", int'(pattern), p);
    check("start_round", int'(round), 0);
    check("start_score", int'(score), 0);
    check("start_done", int'(done), 0);
    check("start_show_q", int'(show_q), 1);
    $display("[TB] start game pattern %0d at cycle %0d", p, cyc);
  endtask

  // Poll for the answer window. Stray strobes may be thrown in while it is closed.
  task automatic wait_window(input bit junk, output int w);
    int n;
    w = -1;
    n = 0;
    while (w < 0) begin
      @(negedge clk);
      ans_valid = 1'b0;
      if (wait_ans) w = cyc;
      else begin
        n++;
        if (n > 200) bound_fail("wait_ans_timeout");
        if (junk && $urandom_range(0, 2) == 0) begin
          ans_valid = 1'b1;
          ans = 2'($urandom);
        end
      end
    end
  endtask

  // Strobe an answer after 'delay' window cycles. An optional second strobe carries a
  // different answer and must be dropped.
  task automatic answer(input int r, input int a, input int delay, input bit dbl);
    int ok;
    exp_t e;
    repeat (delay) @(negedge clk);
    ans_valid = 1'b1;
    ans = 2'(a);
    ok = (a == key[m_pat][r]) ? 1 : 0;
    m_score += ok;
    e.ok = ok;
    e.score = m_score;
    e.rnd = r;
    e.cyc = cyc + 2;
    sb.push_back(e);
    @(negedge clk);
    if (dbl) begin
      ans = ans ^ 2'($urandom_range(1, 3));
      @(negedge clk);
    end
    ans_valid = 1'b0;
  endtask

  task automatic finish_game();
    int n;
    n = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (n > 100) bound_fail("done_timeout");
    end
    check("done", int'(done), 1);
    check("final_score", int'(score), m_score);
    check("final_round", int'(round), 3);
    check("sb_drained", sb.size(), 0);
    $display("[TB] game over pattern %0d score %0d at cycle %0d", m_pat, score, cyc);
  endtask

  task automatic play_game(input int p, input int a[4], input bit junk, input bit dbl_en);
    int w;
    start_game(p);
    for (int r = 0; r < 4; r++) begin
      wait_window(junk, w);
      answer(r, a[r], $urandom_range(0, 3), dbl_en && ($urandom_range(0, 1) == 1));
    end
    finish_game();
  endtask

  // A start pulse in the middle of a game must change nothing.
  task automatic mid_start(input int exp_round);
    @(negedge clk);
    start = 1'b1;
    pattern_sel = 2'(m_pat ^ 1);
    @(negedge clk);
    start = 1'b0;
    check("midstart_pattern", int'(pattern), m_pat);
    check("midstart_round", int'(round), exp_round);
    check("midstart_done", int'(done), 0);
  endtask

  initial begin
    int a[4];
    int w;
    key = '{'{1, 0, 3, 2}, '{2, 3, 0, 1}, '{3, 2, 1, 0}, '{0, 2, 1, 3}};
    reset = 1'b1;
    start = 1'b0;
    pattern_sel = 2'd0;
    ans_valid = 1'b0;
    ans = 2'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Every answer right for pattern 0.
    a = '{1, 0, 3, 2};
    play_game(0, a, 1'b0, 1'b0);
    check("all_right_score", int'(score), 4);

    // Mixed answers with stray strobes outside the window and double strobes inside it.
    a = '{0, 2, 1, 0};
    play_game(2, a, 1'b1, 1'b1);

    // Mid-game start is ignored. Reset in the answer window of q2 abandons the game.
    start_game(3);
    wait_window(1'b0, w);
    answer(0, key[3][0], 1, 1'b0);
    mid_start(0);
    wait_window(1'b0, w);
    answer(1, key[3][1], 0, 1'b0);
    wait_window(1'b0, w);
    check("q2_round", int'(round), 2);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    reset = 1'b0;
    sb.delete();

    // Random games. Each later game starts from DONE, which also covers restart.
    for (int g = 0; g < 6; g++) begin
      int p;
      p = (g == 1) ? 3 : int'($urandom_range(0, 3));
      for (int r = 0; r < 4; r++)
        a[r] = ($urandom_range(0, 1) == 1) ? key[p][r] : int'($urandom_range(0, 3));
      play_game(p, a, 1'b1, 1'b1);
    end

`ifdef QUIZ_TIMEOUT_EN
    begin
      exp_t e;
      int n;
      start_game(1);
      wait_window(1'b0, w);
      e.ok = 0;
      e.score = m_score;
      e.rnd = 0;
      e.cyc = w + TIMEOUT_C;
      sb.push_back(e);
      n = 0;
      while (wait_ans) begin
        @(negedge clk);
        n++;
        if (n > TIMEOUT_C + 10) bound_fail("timeout_window");
      end
      wait_window(1'b0, w);
      answer(1, key[1][1], TIMEOUT_C - 1, 1'b0);
      wait_window(1'b0, w);
      answer(2, key[1][2], 0, 1'b0);
      wait_window(1'b0, w);
      answer(3, 0, 2, 1'b0);
      finish_game();
    end
`endif

    repeat (5) @(negedge clk);
    check("sb_empty_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    bound_fail("global_watchdog");
  end

endmodule
